// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_port_arbiter.
// The arbiter uses the slave modport; the CPU/memory side uses master.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              grant;
   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, grant, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, grant, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and data requesters (IDLE/BUSY/DONE FSM).
// Define MEMARB_RR_EN for round-robin on collisions; otherwise the data port always wins.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned WAIT_CYC = 1
) (
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.slave  bus
);

   localparam logic [3:0] WaitLd = 4'(WAIT_CYC);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              grant_q, grant_d;
   logic              busy_q, busy_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic              any_req;
   logic              win_data;

   assign any_req = bus.if_req | bus.d_req;

`ifdef MEMARB_RR_EN
   logic last_grant_q, last_grant_d;

   // On a collision the port that was not granted last time wins.
   assign win_data = bus.d_req & ~(bus.if_req & last_grant_q);

   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == StIdle && any_req) begin
         last_grant_d = win_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`else
   assign win_data = bus.d_req;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      busy_d      = busy_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_ack_d    = 1'b0;
      d_ack_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               grant_d     = win_data;
               mem_en_d    = 1'b1;
               mem_we_d    = win_data & bus.d_we;
               mem_addr_d  = win_data ? bus.d_addr : bus.if_addr;
               mem_wdata_d = win_data ? bus.d_wdata : '0;
               cnt_d       = WaitLd;
               busy_d      = 1'b1;
               state_d     = StBusy;
            end
         end
         StBusy: begin
            if (cnt_q == 4'd0) begin
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               // Writes leave the port's read-data register untouched.
               if (!mem_we_q) begin
                  if (grant_q) begin
                     d_rdata_d = bus.mem_rdata;
                  end else begin
                     if_rdata_d = bus.mem_rdata;
                  end
               end
               if_ack_d = ~grant_q;
               d_ack_d  = grant_q;
               state_d  = StDone;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         grant_q     <= 1'b0;
         busy_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         busy_q      <= busy_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_ack_q    <= if_ack_d;
         d_ack_q     <= d_ack_d;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.busy      = busy_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.d_ack     = d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: dut1 runs WAIT_CYC=1, dut0 runs WAIT_CYC=0.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic rst1;
   logic rst0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(1)) dut1 (
      .clk   (clk),
      .reset (rst1),
      .bus   (b1.slave)
   );

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(0)) dut0 (
      .clk   (clk),
      .reset (rst0),
      .bus   (b0.slave)
   );

   // Memory contents; data only appears while mem_en is high.
   function automatic logic [31:0] mem_model(input logic [31:0] a);
      case (a)
         32'h0000_0040: mem_model = 32'h8C22_0004;
         32'h0000_0200: mem_model = 32'h1234_5678;
         32'h0000_0000: mem_model = 32'hAAAA_0000;
         32'h0000_0004: mem_model = 32'hBBBB_0004;
         default:       mem_model = ~a;
      endcase
   endfunction

   assign b1.mem_rdata = b1.mem_en ? mem_model(b1.mem_addr) : '0;
   assign b0.mem_rdata = b0.mem_en ? mem_model(b0.mem_addr) : '0;

   task automatic idle_inputs();
      b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0;
      b1.d_addr = '0;   b1.d_wdata = '0;
      b0.if_req = 1'b0; b0.if_addr = '0; b0.d_req = 1'b0; b0.d_we = 1'b0;
      b0.d_addr = '0;   b0.d_wdata = '0;
   endtask

   task automatic test_reset();
      rst1 = 1'b1;
      rst0 = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      tests++;
      if ({b1.if_ack, b1.d_ack, b1.mem_en, b1.mem_we, b1.grant, b1.busy} !== 6'b0) begin
         fails++;
         $display("FAIL reset_ctrl1: got %b expected 000000",
                  {b1.if_ack, b1.d_ack, b1.mem_en, b1.mem_we, b1.grant, b1.busy});
      end
      tests++;
      if ({b1.mem_addr, b1.mem_wdata} !== 64'h0) begin
         fails++;
         $display("FAIL reset_mem1: got %h expected 0", {b1.mem_addr, b1.mem_wdata});
      end
      tests++;
      if ({b1.if_rdata, b1.d_rdata} !== 64'h0) begin
         fails++;
         $display("FAIL reset_rdata1: got %h expected 0", {b1.if_rdata, b1.d_rdata});
      end
      tests++;
      if ({b0.if_ack, b0.d_ack, b0.mem_en, b0.mem_we, b0.grant, b0.busy} !== 6'b0) begin
         fails++;
         $display("FAIL reset_ctrl0: got %b expected 000000",
                  {b0.if_ack, b0.d_ack, b0.mem_en, b0.mem_we, b0.grant, b0.busy});
      end
      rst1 = 1'b0;
      rst0 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fetch_read();
      logic [3:0] e_en   = 4'b0011;
      logic [3:0] e_ack  = 4'b0100;
      logic [3:0] e_busy = 4'b0111;
      b1.if_addr = 32'h40;
      b1.if_req  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests++;
         if (b1.mem_en !== e_en[k]) begin
            fails++; $display("FAIL fetch_en k=%0d: got %b expected %b", k, b1.mem_en, e_en[k]);
         end
         tests++;
         if (b1.if_ack !== e_ack[k]) begin
            fails++; $display("FAIL fetch_ack k=%0d: got %b expected %b", k, b1.if_ack, e_ack[k]);
         end
         tests++;
         if (b1.d_ack !== 1'b0) begin
            fails++; $display("FAIL fetch_dack k=%0d: got %b expected 0", k, b1.d_ack);
         end
         tests++;
         if (b1.busy !== e_busy[k]) begin
            fails++; $display("FAIL fetch_busy k=%0d: got %b expected %b", k, b1.busy, e_busy[k]);
         end
         if (k < 2) begin
            tests++;
            if ({b1.grant, b1.mem_we, b1.mem_addr} !== {2'b00, 32'h40}) begin
               fails++;
               $display("FAIL fetch_bus k=%0d: got g=%b we=%b a=%h expected g=0 we=0 a=00000040",
                        k, b1.grant, b1.mem_we, b1.mem_addr);
            end
         end
         if (k == 2) b1.if_req = 1'b0;
      end
      tests++;
      if (b1.if_rdata !== 32'h8C22_0004) begin
         fails++; $display("FAIL fetch_rdata: got %h expected 8c220004", b1.if_rdata);
      end
   endtask

   task automatic test_data_write();
      logic [3:0] e_ack = 4'b0100;
      b1.d_we    = 1'b1;
      b1.d_addr  = 32'h100;
      b1.d_wdata = 32'hDEAD_BEEF;
      b1.d_req   = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k < 2) begin
            tests++;
            if ({b1.grant, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata} !==
                {3'b111, 32'h100, 32'hDEAD_BEEF}) begin
               fails++;
               $display("FAIL write_bus k=%0d: got g=%b en=%b we=%b a=%h wd=%h expected 1 1 1 100 deadbeef",
                        k, b1.grant, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata);
            end
         end else begin
            tests++;
            if ({b1.mem_en, b1.mem_we} !== 2'b00) begin
               fails++; $display("FAIL write_drop k=%0d: got %b expected 00", k, {b1.mem_en, b1.mem_we});
            end
         end
         tests++;
         if ({b1.d_ack, b1.if_ack} !== {e_ack[k], 1'b0}) begin
            fails++;
            $display("FAIL write_ack k=%0d: got d=%b i=%b expected d=%b i=0", k, b1.d_ack, b1.if_ack, e_ack[k]);
         end
         if (k == 2) b1.d_req = 1'b0;
      end
      tests++;
      if (b1.d_rdata !== 32'h0) begin
         fails++; $display("FAIL write_rdata: got %h expected 00000000", b1.d_rdata);
      end
      tests++;
      if (b1.if_rdata !== 32'h8C22_0004) begin
         fails++; $display("FAIL rdata_hold: got %h expected 8c220004", b1.if_rdata);
      end
   endtask

   task automatic test_collision();
      logic       first_data;
      logic [7:0] e_busy = 8'b0111_0111;
      logic       e_dack;
      logic       e_iack;
`ifdef MEMARB_RR_EN
      first_data = 1'b0;  // data port won last, so fetch goes first
`else
      first_data = 1'b1;
`endif
      b1.d_we    = 1'b0;
      b1.d_addr  = 32'h200;
      b1.if_addr = 32'h44;
      b1.d_req   = 1'b1;
      b1.if_req  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         e_dack = first_data ? (k == 2) : (k == 6);
         e_iack = first_data ? (k == 6) : (k == 2);
         tests++;
         if ({b1.d_ack, b1.if_ack} !== {e_dack, e_iack}) begin
            fails++;
            $display("FAIL coll_ack k=%0d: got d=%b i=%b expected d=%b i=%b",
                     k, b1.d_ack, b1.if_ack, e_dack, e_iack);
         end
         tests++;
         if (b1.busy !== e_busy[k]) begin
            fails++; $display("FAIL coll_busy k=%0d: got %b expected %b", k, b1.busy, e_busy[k]);
         end
         if (k == 0 || k == 4) begin
            tests++;
            if (b1.grant !== ((k == 0) ? first_data : !first_data)) begin
               fails++; $display("FAIL coll_grant k=%0d: got %b", k, b1.grant);
            end
            tests++;
            if (b1.mem_addr !== (((k == 0) == first_data) ? 32'h200 : 32'h44)) begin
               fails++; $display("FAIL coll_addr k=%0d: got %h", k, b1.mem_addr);
            end
         end
         if (e_dack) b1.d_req = 1'b0;
         if (e_iack) b1.if_req = 1'b0;
      end
      tests++;
      if ({b1.d_rdata, b1.if_rdata} !== {32'h1234_5678, 32'hFFFF_FFBB}) begin
         fails++;
         $display("FAIL coll_rdata: got d=%h i=%h expected d=12345678 i=ffffffbb", b1.d_rdata, b1.if_rdata);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [3:0] e_ack = 4'b0100;
      b1.if_addr = 32'h80;
      b1.if_req  = 1'b1;
      repeat (2) @(negedge clk);
      rst1      = 1'b1;
      b1.if_req = 1'b0;
      @(negedge clk);
      tests++;
      if ({b1.mem_en, b1.busy, b1.if_ack, b1.d_ack, b1.grant, b1.mem_we} !== 6'b0) begin
         fails++;
         $display("FAIL rstmid_ctrl: got %b expected 000000",
                  {b1.mem_en, b1.busy, b1.if_ack, b1.d_ack, b1.grant, b1.mem_we});
      end
      tests++;
      if ({b1.mem_addr, b1.if_rdata, b1.d_rdata} !== 96'h0) begin
         fails++;
         $display("FAIL rstmid_data: got a=%h i=%h d=%h expected 0", b1.mem_addr, b1.if_rdata, b1.d_rdata);
      end
      rst1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests++;
         if ({b1.if_ack, b1.busy} !== 2'b00) begin
            fails++; $display("FAIL rstmid_quiet k=%0d: got %b expected 00", k, {b1.if_ack, b1.busy});
         end
      end
      b1.if_addr = 32'h40;
      b1.if_req  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests++;
         if (b1.if_ack !== e_ack[k]) begin
            fails++; $display("FAIL rstmid_ack k=%0d: got %b expected %b", k, b1.if_ack, e_ack[k]);
         end
         if (k == 2) b1.if_req = 1'b0;
      end
      tests++;
      if (b1.if_rdata !== 32'h8C22_0004) begin
         fails++; $display("FAIL rstmid_rdata: got %h expected 8c220004", b1.if_rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] e_ack  = 7'b001_0010;
      logic [6:0] e_en   = 7'b000_1001;
      logic [6:0] e_busy = 7'b001_1011;
      b0.if_addr = 32'h0;
      b0.if_req  = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         tests++;
         if ({b0.if_ack, b0.mem_en, b0.busy} !== {e_ack[k], e_en[k], e_busy[k]}) begin
            fails++;
            $display("FAIL b2b_ctrl k=%0d: got ack=%b en=%b busy=%b expected %b %b %b",
                     k, b0.if_ack, b0.mem_en, b0.busy, e_ack[k], e_en[k], e_busy[k]);
         end
         if (k == 0 || k == 3) begin
            tests++;
            if (b0.mem_addr !== ((k == 0) ? 32'h0 : 32'h4)) begin
               fails++; $display("FAIL b2b_addr k=%0d: got %h", k, b0.mem_addr);
            end
         end
         if (k == 1) begin
            tests++;
            if (b0.if_rdata !== 32'hAAAA_0000) begin
               fails++; $display("FAIL b2b_rdata0: got %h expected aaaa0000", b0.if_rdata);
            end
            b0.if_addr = 32'h4;
         end
         if (k == 4) begin
            tests++;
            if (b0.if_rdata !== 32'hBBBB_0004) begin
               fails++; $display("FAIL b2b_rdata1: got %h expected bbbb0004", b0.if_rdata);
            end
            b0.if_req = 1'b0;
         end
      end
   endtask

   task automatic test_req_drop();
      logic [5:0] e_ack  = 6'b00_0100;
      logic [5:0] e_busy = 6'b00_0111;
      b1.d_we   = 1'b0;
      b1.d_addr = 32'h0;
      b1.d_req  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         tests++;
         if ({b1.d_ack, b1.if_ack, b1.busy} !== {e_ack[k], 1'b0, e_busy[k]}) begin
            fails++;
            $display("FAIL drop_ctrl k=%0d: got d=%b i=%b busy=%b expected %b 0 %b",
                     k, b1.d_ack, b1.if_ack, b1.busy, e_ack[k], e_busy[k]);
         end
         if (k == 0) begin
            b1.d_req  = 1'b0;
            b1.d_addr = 32'h4;
         end
         if (k == 1) begin
            tests++;
            if (b1.mem_addr !== 32'h0) begin
               fails++; $display("FAIL drop_addr: got %h expected 00000000", b1.mem_addr);
            end
         end
      end
      tests++;
      if (b1.d_rdata !== 32'hAAAA_0000) begin
         fails++; $display("FAIL drop_rdata: got %h expected aaaa0000", b1.d_rdata);
      end
   endtask

   initial begin
      rst1 = 1'b1;
      rst0 = 1'b1;
      idle_inputs();
      test_reset();
      test_fetch_read();
      test_data_write();
      test_collision();
      test_reset_mid_op();
      test_back_to_back();
      test_req_drop();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got no summary expected completion");
      $fatal(1, "watchdog");
   end

endmodule
